// File: rtl/exec_pkg.sv
// Shared types for the execute datapath: ALU op codes, the EX pipeline register, and the ALU itself.
// MUL_EN enables the MUL op in alu(); without it MUL falls through to the undefined-op result.
package exec_pkg;
  localparam int MAX_XLEN = 64;
  localparam int MAX_AW   = 8;
  localparam int A0_IDX   = 10;

  typedef enum logic [3:0] {
    ADD = 4'd0, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL
  } alu_op_e;

  typedef struct packed {
    logic [MAX_XLEN-1:0] op_a;
    logic [MAX_XLEN-1:0] op_b;
    logic [MAX_XLEN-1:0] rs2v;
    logic [MAX_AW-1:0]   rd;
    logic                reg_write;
    alu_op_e             alu_op;
  } ex_reg_t;

  // Operands arrive zero-extended from xlen bits; signed ops re-extend from bit xlen-1.
  function automatic logic [MAX_XLEN-1:0] alu(input alu_op_e op,
                                              input logic [MAX_XLEN-1:0] a,
                                              input logic [MAX_XLEN-1:0] b,
                                              input int xlen);
    logic signed [MAX_XLEN-1:0] sa, sb;
    logic [5:0] sh;
    int pad;
    pad = MAX_XLEN - xlen;
    sa  = $signed(a << pad) >>> pad;
    sb  = $signed(b << pad) >>> pad;
    sh  = b[5:0] & 6'(xlen - 1);
    case (op)
      ADD:  alu = a + b;
      SUB:  alu = a - b;
      AND:  alu = a & b;
      OR:   alu = a | b;
      XOR:  alu = a ^ b;
      SLL:  alu = a << sh;
      SRL:  alu = a >> sh;
      SRA:  alu = sa >>> sh;
      SLT:  alu = MAX_XLEN'(sa < sb);
      SLTU: alu = MAX_XLEN'(a < b);
`ifdef MUL_EN
      MUL:  alu = a * b;
`endif
      default: alu = '0;
    endcase
  endfunction
endpackage

// File: rtl/exec_datapath_regfile.sv
// Two-read one-write register file with hard-wired zero register and an x10 (a0) tap.
module regfile_2r1w
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] a0
);
  logic [NREGS-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                regs     <= '0;
    else if (we && wa != '0)   regs[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
  assign a0  = regs[A0_IDX];
endmodule

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: READ latches operands into EX, EX computes, writes back and reports.
// MUL_EN adds a multi-cycle multiply that holds EX for MUL_LAT cycles and stalls issue.
module exec_datapath
  import exec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int MUL_LAT = 4,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            reg_write,
  input  logic [XLEN-1:0] imm_op,
  input  logic            alu_src,
  input  alu_op_e         alu_op,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [AW-1:0]   out_rd,
  output logic            out_eq,
  output logic [XLEN-1:0] a0
);
  ex_reg_t         ex;
  logic            ex_valid, ex_done, accept, wb_en, fwd1, fwd2;
  logic [XLEN-1:0] rf1, rf2, rs1v, rs2v, ex_res;

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .ra1(rs1), .ra2(rs2), .rd1(rf1), .rd2(rf2),
    .we(wb_en), .wa(ex.rd[AW-1:0]), .wd(ex_res), .a0(a0)
  );

  assign ex_res = XLEN'(alu(ex.alu_op, ex.op_a, ex.op_b, XLEN));

`ifdef MUL_EN
  localparam int CW = $clog2(MUL_LAT);
  logic [CW-1:0] mul_cnt;

  assign ex_done  = ex_valid && (ex.alu_op != MUL || mul_cnt == CW'(MUL_LAT - 1));
  // Only a multiply can sit in EX without completing.
  assign in_ready = !ex_valid || ex_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mul_cnt <= '0;
    else if (ex_done)  mul_cnt <= '0;
    else if (ex_valid) mul_cnt <= mul_cnt + CW'(1);
  end
`else
  assign ex_done  = ex_valid;
  assign in_ready = 1'b1;
`endif

  assign accept = in_valid && in_ready;
  assign wb_en  = ex_done && ex.reg_write && ex.rd != '0;
  assign fwd1   = wb_en && ex.rd == MAX_AW'(rs1);
  assign fwd2   = wb_en && ex.rd == MAX_AW'(rs2);
  assign rs1v   = fwd1 ? ex_res : rf1;
  assign rs2v   = fwd2 ? ex_res : rf2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex       <= '0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex.op_a      <= MAX_XLEN'(rs1v);
      ex.op_b      <= MAX_XLEN'(alu_src ? imm_op : rs2v);
      ex.rs2v      <= MAX_XLEN'(rs2v);
      ex.rd        <= MAX_AW'(rd);
      ex.reg_write <= reg_write;
      ex.alu_op    <= alu_op;
    end else if (ex_done) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_eq     <= 1'b0;
    end else begin
      out_valid <= ex_done;
      if (ex_done) begin
        out_result <= ex_res;
        out_rd     <= ex.rd[AW-1:0];
        out_eq     <= ex.op_a == ex.rs2v;
      end
    end
  end
endmodule

// File: tb/tb_exec_datapath.sv
// Directed bench for exec_datapath with an in-order scoreboard and a reference register model.
module tb_exec_datapath;
  import exec_pkg::*;

  localparam int MUL_LAT = 4;
`ifdef MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, reg_write = 1'b0, alu_src = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] imm_op = '0;
  alu_op_e     alu_op = ADD;
  logic        in_ready, out_valid, out_eq;
  logic [31:0] out_result, a0;
  logic [4:0]  out_rd;

  exec_datapath #(.XLEN(32), .NREGS(32), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .imm_op(imm_op),
    .alu_src(alu_src), .alu_op(alu_op), .out_valid(out_valid),
    .out_result(out_result), .out_rd(out_rd), .out_eq(out_eq), .a0(a0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        eq;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg [32];
  int n_cmp = 0, n_err = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      ADD:  return a + b;
      SUB:  return a - b;
      AND:  return a & b;
      OR:   return a | b;
      XOR:  return a ^ b;
      SLL:  return a << sh;
      SRL:  return a >> sh;
      SRA:  return $unsigned($signed(a) >>> sh);
      SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: return (a < b) ? 32'd1 : 32'd0;
      MUL:  return MUL_ON ? a * b : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_eq", 32'(out_eq), 32'(e.eq));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic we, input logic [31:0] imm, input logic src,
                       input alu_op_e op, output int stalls);
    exp_t e;
    logic [31:0] a, b2, b;
    @(negedge clk);
    in_valid = 1'b1; rs1 = r1; rs2 = r2; rd = d; reg_write = we;
    imm_op = imm; alu_src = src; alu_op = op;
    stalls = 0;
    while (!in_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a  = mreg[r1];
    b2 = mreg[r2];
    b  = src ? imm : b2;
    e.res = model(op, a, b);
    e.rd  = d;
    e.eq  = (a == b2);
    e.cyc = cyc + ((op == MUL && MUL_ON) ? MUL_LAT + 1 : 2);
    if (we && d != 5'd0) mreg[d] = e.res;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic iss(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                     input logic we, input logic [31:0] imm, input logic src, input alu_op_e op);
    int st;
    issue(r1, r2, d, we, imm, src, op, st);
  endtask

  // Asynchronous reset mid-cycle; outputs are checked while reset is still held.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    foreach (mreg[i]) mreg[i] = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_eq", 32'(out_eq), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a0", a0, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int st, n;
    foreach (mreg[i]) mreg[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset in the middle of a stream, then registers read back as zero
    iss(0, 0, 3, 1, 32'h55, 1, ADD);
    iss(3, 0, 4, 1, 32'h0, 0, XOR);
    do_reset();
    iss(3, 0, 0, 0, 32'h0, 0, ADD);
    iss(4, 4, 0, 0, 32'h0, 0, OR);

    // back-to-back dependence through the forward path
    iss(0, 0, 10, 1, 32'd5, 1, ADD);
    iss(10, 10, 10, 1, 32'd0, 0, ADD);
    repeat (3) @(negedge clk);
    chk("a0_after_dep", a0, 32'd10);

    // x0 stays zero
    iss(0, 0, 0, 1, 32'd7, 1, ADD);
    iss(0, 0, 1, 1, 32'd0, 0, ADD);
    iss(1, 1, 0, 0, 32'd0, 0, ADD);

    // arithmetic edges
    iss(0, 0, 3, 1, 32'd1, 1, ADD);
    iss(0, 3, 4, 1, 32'd0, 0, SUB);
    iss(0, 0, 5, 1, 32'h8000_0000, 1, ADD);
    iss(5, 0, 6, 1, 32'd31, 1, SRA);
    iss(4, 3, 7, 1, 32'd0, 0, SLT);
    iss(4, 3, 8, 1, 32'd0, 0, SLTU);
    iss(0, 0, 8, 1, 32'h1234, 1, ADD);
    iss(0, 0, 9, 1, 32'h1234, 1, ADD);
    iss(8, 9, 2, 1, 32'h5, 1, ADD);
    iss(4, 3, 11, 1, 32'd0, 0, SLL);
    iss(4, 0, 12, 1, 32'd36, 1, SRL);
    iss(4, 5, 13, 1, 32'd0, 0, AND);
    iss(4, 0, 14, 1, 32'd0, 0, alu_op_e'(4'd15));
    iss(14, 0, 0, 0, 32'd0, 0, ADD);
    iss(3, 4, 15, 1, 32'd0, 0, MUL);
    iss(15, 0, 0, 0, 32'd0, 0, ADD);

`ifdef MUL_EN
    // multi-cycle multiply with a dependent instruction held on in_valid
    iss(0, 0, 11, 1, 32'd6, 1, ADD);
    iss(0, 0, 12, 1, 32'd7, 1, ADD);
    iss(11, 12, 5, 1, 32'd0, 0, MUL);
    issue(5, 0, 6, 1, 32'd0, 0, ADD, st);
    chk("mul_stall_cycles", 32'(st), 32'd3);
    iss(6, 5, 0, 0, 32'd0, 0, ADD);
`endif

    // reset during a multiply's second cycle aborts it
    iss(0, 0, 11, 1, 32'd6, 1, ADD);
    iss(0, 0, 12, 1, 32'd7, 1, ADD);
    iss(11, 12, 13, 1, 32'd0, 0, MUL);
    @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("no_out_after_rst", 32'(out_valid), 32'd0);
    end
    iss(13, 0, 0, 0, 32'd0, 0, ADD);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
